// File: rtl/dsc_mul_seq_if.sv
// dsc_mul_seq_if: host-side handshake bundle for the DSC multiplier sequencer.
//   in_valid/in_ready + in_a..in_d : operand set offered by the host or operand FIFO
//   out_valid/out_ready            : result handshake toward the consumer
//   out_z                          : captured binary product
//   out_cycles                     : number of enabled datapath cycles for the job
// Modports: master = host side, slave = sequencer side.
interface dsc_mul_seq_if #(
  parameter int SNG_WIDTH  = 10,
  parameter int NUM_INPUTS = 4,
  parameter int RUN_LOG2   = NUM_INPUTS * SNG_WIDTH
);
  logic                            in_valid;
  logic                            in_ready;
  logic [SNG_WIDTH-1:0]            in_a;
  logic [SNG_WIDTH-1:0]            in_b;
  logic [SNG_WIDTH-1:0]            in_c;
  logic [SNG_WIDTH-1:0]            in_d;
  logic                            out_valid;
  logic                            out_ready;
  logic [NUM_INPUTS*SNG_WIDTH-1:0] out_z;
  logic [RUN_LOG2:0]               out_cycles;

  modport master (
    output in_valid, in_a, in_b, in_c, in_d, out_ready,
    input  in_ready, out_valid, out_z, out_cycles
  );

  modport slave (
    input  in_valid, in_a, in_b, in_c, in_d, out_ready,
    output in_ready, out_valid, out_z, out_cycles
  );
endinterface

// File: rtl/dsc_mul_seq.sv
// dsc_mul_seq: sequencer for the serial 4-input deterministic stochastic-computing
// multiplier datapath. One job in flight at a time.
//
// Ports:
//   clk          single clock, rising edge
//   rst          asynchronous active-low reset
//   host         dsc_mul_seq_if.slave (operand handshake in, result handshake out)
//   dp_a..dp_d   latched operands to the datapath, stable for the whole job
//   dp_clr       one-cycle datapath clear pulse
//   dp_en        datapath enable
//   dp_z         datapath product counter value
//   dp_ov        datapath "remaining stream is zero / wrapped" flag
//   busy         high whenever the sequencer is not idle
//
// Build option: DSC_SEQ_EARLY_STOP_EN - when defined, dp_ov sampled high in RUN
// ends the run after that (still enabled) cycle. When undefined dp_ov is ignored.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand set
// CLEAR | one-cycle datapath clear, run counter zeroed
// RUN   | datapath enabled, run counter counting enabled cycles
// DRAIN | datapath disabled one cycle so its counter settles, then capture
// DONE  | result held with out_valid until out_ready
module dsc_mul_seq #(
  parameter int SNG_WIDTH  = 10,
  parameter int NUM_INPUTS = 4,
  parameter int RUN_LOG2   = NUM_INPUTS * SNG_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  dsc_mul_seq_if.slave                    host,
  output logic [SNG_WIDTH-1:0]            dp_a,
  output logic [SNG_WIDTH-1:0]            dp_b,
  output logic [SNG_WIDTH-1:0]            dp_c,
  output logic [SNG_WIDTH-1:0]            dp_d,
  output logic                            dp_clr,
  output logic                            dp_en,
  input  logic [NUM_INPUTS*SNG_WIDTH-1:0] dp_z,
  input  logic                            dp_ov,
  output logic                            busy
);

  if (NUM_INPUTS != 4) begin : g_num_inputs_check
    $error("dsc_mul_seq: NUM_INPUTS must be 4 to match the operand port list");
  end

  localparam int ZW = NUM_INPUTS * SNG_WIDTH;

  // Last counter value of a full run: 2^RUN_LOG2 - 1, built without integer shifts
  // so wide RUN_LOG2 values do not overflow 32-bit arithmetic.
  localparam logic [RUN_LOG2:0] RUN_LAST = {1'b0, {RUN_LOG2{1'b1}}};
  localparam logic [RUN_LOG2:0] RUN_ONE  = {{RUN_LOG2{1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_RUN   = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [RUN_LOG2:0] run_cnt;
  logic [ZW-1:0]     out_z_q;
  logic [RUN_LOG2:0] out_cycles_q;
  logic              any_zero;
  logic              stop_early;

  assign any_zero = (host.in_a == '0) || (host.in_b == '0) ||
                    (host.in_c == '0) || (host.in_d == '0);

`ifdef DSC_SEQ_EARLY_STOP_EN
  assign stop_early = dp_ov;
`else
  logic unused_dp_ov;
  assign unused_dp_ov = dp_ov;
  assign stop_early   = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (host.in_valid) state_nxt = any_zero ? S_DONE : S_CLEAR;
      S_CLEAR: state_nxt = S_RUN;
      S_RUN:   if ((run_cnt == RUN_LAST) || stop_early) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  if (host.out_ready) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    host.in_ready  = 1'b0;
    host.out_valid = 1'b0;
    dp_clr         = 1'b0;
    dp_en          = 1'b0;
    busy           = 1'b1;
    case (state)
      S_IDLE: begin
        host.in_ready = 1'b1;
        busy          = 1'b0;
      end
      S_CLEAR: dp_clr         = 1'b1;
      S_RUN:   dp_en          = 1'b1;
      S_DONE:  host.out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operand latch, run counter and result capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dp_a         <= '0;
      dp_b         <= '0;
      dp_c         <= '0;
      dp_d         <= '0;
      run_cnt      <= '0;
      out_z_q      <= '0;
      out_cycles_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (host.in_valid) begin
            dp_a <= host.in_a;
            dp_b <= host.in_b;
            dp_c <= host.in_c;
            dp_d <= host.in_d;
            // A zero operand forces a zero product; skip the datapath entirely.
            if (any_zero) begin
              out_z_q      <= '0;
              out_cycles_q <= '0;
            end
          end
        end
        S_CLEAR: run_cnt <= '0;
        S_RUN:   run_cnt <= run_cnt + RUN_ONE;
        S_DRAIN: begin
          out_z_q      <= dp_z;
          out_cycles_q <= run_cnt;
        end
        default: ;
      endcase
    end
  end

  assign host.out_z      = out_z_q;
  assign host.out_cycles = out_cycles_q;

endmodule

// File: tb/tb_dsc_mul_seq.sv
// tb_dsc_mul_seq: directed bench for dsc_mul_seq with SNG_WIDTH=2, RUN_LOG2=8.
// The datapath model counts enabled cycles where all four unary streams are high;
// stream k is high while digit k (bits 2k+1:2k) of the enabled-cycle index is
// below operand k, so a full run counts a*b*c*d.
module tb_dsc_mul_seq;
  localparam int SW = 2;
  localparam int NI = 4;
  localparam int RL = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [SW-1:0]    dp_a, dp_b, dp_c, dp_d;
  logic             dp_clr, dp_en, dp_ov, busy;
  logic [NI*SW-1:0] dp_z;

  dsc_mul_seq_if #(.SNG_WIDTH(SW), .NUM_INPUTS(NI), .RUN_LOG2(RL)) hif ();

  dsc_mul_seq #(.SNG_WIDTH(SW), .NUM_INPUTS(NI), .RUN_LOG2(RL)) dut (
    .clk   (clk),
    .rst   (rst),
    .host  (hif),
    .dp_a  (dp_a),
    .dp_b  (dp_b),
    .dp_c  (dp_c),
    .dp_d  (dp_d),
    .dp_clr(dp_clr),
    .dp_en (dp_en),
    .dp_z  (dp_z),
    .dp_ov (dp_ov),
    .busy  (busy)
  );

  int checks   = 0;
  int failures = 0;
  int en_cnt   = 0;
  int clr_cnt  = 0;
  int lat;
  logic       ov_arm = 1'b0;
  logic [8:0] m_idx;
  logic [7:0] m_cnt;

`ifdef DSC_SEQ_EARLY_STOP_EN
  localparam int ES_CYC = 65;
`else
  localparam int ES_CYC = 256;
`endif

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_idx <= '0;
      m_cnt <= '0;
    end else if (dp_clr) begin
      m_idx <= '0;
      m_cnt <= '0;
    end else if (dp_en) begin
      m_idx <= m_idx + 9'd1;
      if ((m_idx[1:0] < dp_a) && (m_idx[3:2] < dp_b) &&
          (m_idx[5:4] < dp_c) && (m_idx[7:6] < dp_d))
        m_cnt <= m_cnt + 8'd1;
    end
  end

  assign dp_z  = m_cnt;
  assign dp_ov = ov_arm && dp_en && (m_idx == 9'd64);

  always @(negedge clk) begin
    if (dp_en)  en_cnt  = en_cnt + 1;
    if (dp_clr) clr_cnt = clr_cnt + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Offer one operand set and return one cycle after the accepting edge.
  task automatic start_job(input logic [SW-1:0] a, b, c, d);
    int n;
    n = 0;
    while (!hif.in_ready && n < 50) begin
      step();
      n++;
    end
    check("in_ready_before_job", hif.in_ready, 1);
    en_cnt  = 0;
    clr_cnt = 0;
    hif.in_valid = 1'b1;
    hif.in_a = a;
    hif.in_b = b;
    hif.in_c = c;
    hif.in_d = d;
    step();
    hif.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int exp_lat, input string tag);
    lat = 1;
    while (!hif.out_valid && lat < 400) begin
      step();
      lat++;
    end
    check(tag, lat, exp_lat);
  endtask

  initial begin
    hif.in_valid  = 1'b1;
    hif.in_a      = 2'd1;
    hif.in_b      = 2'd1;
    hif.in_c      = 2'd1;
    hif.in_d      = 2'd1;
    hif.out_ready = 1'b1;

    // Reset: in_valid offered but must be ignored.
    repeat (3) step();
    check("rst_in_ready", hif.in_ready, 1);
    check("rst_busy", busy, 0);
    hif.in_valid = 1'b0;
    rst = 1'b1;
    step();
    check("idle_in_ready", hif.in_ready, 1);
    check("idle_out_valid", hif.out_valid, 0);
    check("idle_busy", busy, 0);
    check("idle_dp_en", dp_en, 0);
    check("idle_out_z", hif.out_z, 0);
    check("idle_dp_a", dp_a, 0);

    // Full job 2*2*2*2.
    start_job(2'd2, 2'd2, 2'd2, 2'd2);
    check("full_clr_now", dp_clr, 1);
    check("full_busy", busy, 1);
    check("full_in_ready", hif.in_ready, 0);
    wait_done(259, "full_latency");
    check("full_clr_pulses", clr_cnt, 1);
    check("full_en_cycles", en_cnt, 256);
    check("full_out_z", hif.out_z, 16);
    check("full_out_cycles", hif.out_cycles, 256);
    check("full_dp_d", dp_d, 2);
    step();
    check("full_valid_drop", hif.out_valid, 0);
    check("full_back_idle", hif.in_ready, 1);

    // Zero-skip.
    start_job(2'd3, 2'd0, 2'd1, 2'd2);
    check("zs_out_valid", hif.out_valid, 1);
    check("zs_out_z", hif.out_z, 0);
    check("zs_out_cycles", hif.out_cycles, 0);
    check("zs_clr", clr_cnt, 0);
    check("zs_en", en_cnt, 0);
    check("zs_dp_a", dp_a, 3);
    check("zs_dp_b", dp_b, 0);
    step();
    check("zs_valid_drop", hif.out_valid, 0);

    // Backpressure: product 3*2*1*3 = 18, held for 20 cycles.
    hif.out_ready = 1'b0;
    start_job(2'd3, 2'd2, 2'd1, 2'd3);
    wait_done(259, "bp_latency");
    hif.in_valid = 1'b1;
    hif.in_a = 2'd1;
    hif.in_b = 2'd1;
    hif.in_c = 2'd0;
    hif.in_d = 2'd1;
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", hif.out_valid, 1);
      check("bp_out_z", hif.out_z, 18);
      check("bp_out_cycles", hif.out_cycles, 256);
      check("bp_in_ready", hif.in_ready, 0);
      step();
    end
    check("bp_dp_a_held", dp_a, 3);
    hif.out_ready = 1'b1;
    check("bp_in_ready_hs", hif.in_ready, 0);
    step();
    check("bp_after_hs_valid", hif.out_valid, 0);
    check("bp_after_hs_ready", hif.in_ready, 1);
    check("bp_not_yet_taken", dp_c, 1);
    step();
    check("bp2_out_valid", hif.out_valid, 1);
    check("bp2_dp_c", dp_c, 0);
    check("bp2_out_z", hif.out_z, 0);
    hif.in_valid = 1'b0;
    step();
    check("bp2_valid_drop", hif.out_valid, 0);

    // Early stop stimulus: dp_ov at RUN index 64; product 27 either way.
    ov_arm = 1'b1;
    start_job(2'd3, 2'd3, 2'd3, 2'd1);
    wait_done(ES_CYC + 3, "es_latency");
    check("es_en_cycles", en_cnt, ES_CYC);
    check("es_out_cycles", hif.out_cycles, ES_CYC);
    check("es_out_z", hif.out_z, 27);
    ov_arm = 1'b0;
    step();

    // Reset mid-RUN at RUN index 100.
    start_job(2'd2, 2'd2, 2'd2, 2'd2);
    lat = 0;
    while (m_idx != 9'd100 && lat < 400) begin
      step();
      lat++;
    end
    check("mr_reach_100", m_idx, 100);
    check("mr_dp_en_before", dp_en, 1);
    check("mr_en_so_far", en_cnt, 100);
    rst = 1'b0;
    #1;
    check("mr_dp_en_async", dp_en, 0);
    check("mr_idle", hif.in_ready, 1);
    check("mr_busy", busy, 0);
    check("mr_out_cycles", hif.out_cycles, 0);
    check("mr_dp_a", dp_a, 0);
    repeat (3) begin
      step();
      check("mr_no_valid", hif.out_valid, 0);
    end
    rst = 1'b1;
    step();
    check("mr_no_valid_after", hif.out_valid, 0);

    // Next job after reset: 3*3*3*3 = 81.
    start_job(2'd3, 2'd3, 2'd3, 2'd3);
    wait_done(259, "post_latency");
    check("post_out_z", hif.out_z, 81);
    check("post_out_cycles", hif.out_cycles, 256);
    check("post_en_cycles", en_cnt, 256);
    step();
    check("post_valid_drop", hif.out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dsc_mul_seq.md
Name: dsc_mul_seq

Overview:
- Sequencer for the serial 4-input deterministic stochastic-computing multiplier datapath.
- Accepts one operand set per job through a valid/ready handshake, latches the operands, and clears the datapath.
- Enables the datapath for one full unary-stream period, or less when terminating early. It then captures the binary product and holds it behind an output valid/ready handshake.
- Sits between the host or operand FIFO and a single multiplier instance; one job is in flight at a time.

Parameters:
- SNG_WIDTH, 10, bit width of each operand and each stream generator.
- NUM_INPUTS, 4, operand count (fixed at 4 by the port list; checked at elaboration).
- RUN_LOG2, NUM_INPUTS*SNG_WIDTH, log2 of full run length in cycles; overridden smaller in simulation.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand set offered
- in_ready  out  1  sequencer accepts operands (high only in IDLE)
- in_a, in_b, in_c, in_d  in  SNG_WIDTH each  operands
- dp_a, dp_b, dp_c, dp_d  out  SNG_WIDTH each  latched operands to datapath, stable for the whole job
- dp_clr  out  1  active-high datapath clear, one-cycle pulse
- dp_en  out  1  datapath enable
- dp_z  in  NUM_INPUTS*SNG_WIDTH  datapath product counter value
- dp_ov  in  1  datapath "remaining stream is zero / wrapped" flag
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_z  out  NUM_INPUTS*SNG_WIDTH  captured product
- out_cycles  out  RUN_LOG2+1  number of cycles dp_en was high for this job
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst low, asynchronous):
  - state = IDLE; operand regs, out_z, out_cycles, the run counter and out_valid all 0; dp_clr = dp_en = 0.
  - in_ready is 1 in IDLE, but in_valid is ignored while rst is low.
  - A reset mid-job aborts immediately; no result is produced.
- All outputs decode from registered state. No combinational path exists from dp_ov or in_valid to any output.
- FSM states: IDLE, CLEAR, RUN, DRAIN, DONE.
  - IDLE: in_ready = 1. When in_valid is high, latch in_a..in_d into dp_a..dp_d.
    - If any operand == 0, set out_z = 0 and out_cycles = 0 and go to DONE (zero-skip, no datapath activity).
    - Otherwise go to CLEAR.
  - CLEAR: dp_clr = 1, dp_en = 0, run counter := 0; next state RUN.
  - RUN: dp_en = 1; run counter += 1 each cycle.
    - Exit to DRAIN after the cycle in which the counter equals 2^RUN_LOG2 - 1, so exactly 2^RUN_LOG2 enabled cycles.
    - Early exit per the optional feature.
  - DRAIN: dp_en = 0 for one cycle so the datapath counter settles. At the end of DRAIN, capture out_z := dp_z and out_cycles := run counter value; go to DONE.
  - DONE: out_valid = 1; out_z and out_cycles held stable. When out_ready is high, go to IDLE and drop out_valid the next cycle.
- Latency from accept to out_valid = 2^RUN_LOG2 + 3 cycles on a full run; 1 cycle on zero-skip.
- The run counter is RUN_LOG2+1 bits, so 2^RUN_LOG2 is representable and never wraps.
- dp_z overflow is the datapath's concern; the sequencer captures it verbatim.
- in_ready = 0 in DONE even if out_ready is high; back-to-back jobs have a one-cycle IDLE bubble.

Optional Feature:
- Macro: DSC_SEQ_EARLY_STOP_EN.
- Defined: in RUN, if dp_ov is sampled high, that cycle counts as enabled and the next state is DRAIN. out_cycles reports the shortened length.
- Not defined: dp_ov is ignored; every non-zero job runs exactly 2^RUN_LOG2 cycles.

Test Plan (SNG_WIDTH=2, RUN_LOG2=8; bench datapath model: dp_z counts cycles with dp_en=1 and all four unary streams high, dp_ov driven by the bench):
- Reset then idle: rst low for 3 cycles, then release -> in_ready=1, out_valid=0, busy=0, dp_en=0, out_z=0.
- Full job, a=b=c=d=2, out_ready=1:
  - dp_clr pulses exactly 1 cycle, then dp_en is high for exactly 256 cycles.
  - out_valid rises 259 cycles after accept, with out_z=16 and out_cycles=256.
- Zero-skip, a=3, b=0, c=1, d=2: dp_clr and dp_en never assert; out_valid next cycle with out_z=0 and out_cycles=0.
- Backpressure, out_ready=0 for 20 cycles after out_valid: out_valid, out_z and out_cycles held; in_ready=0; a second in_valid is not accepted until 1 cycle after the out_ready handshake.
- Early stop (macro defined), a=b=c=3, d=1, bench raises dp_ov on RUN cycle index 64 -> dp_en high for 65 cycles, out_cycles=65, out_z equals the model count. With the macro undefined, the same stimulus gives out_cycles=256.
- Reset mid-RUN, rst low at RUN cycle 100: dp_en drops asynchronously, state IDLE, out_valid never asserts; the next job completes normally.
